// File: rtl/instr_fetch.sv
// Instruction fetch: issues in-order word reads to imem, buffers {pc, instr} in a
// small FIFO for decode, and flushes on execute redirects.
module instr_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [6:0]  o_opcode
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];

  logic [CW:0]   inflight;
  logic [31:0]   redir_pc;
  logic          head_vld, grant, push, pop;

  // Credit covers both words still owed by memory and words already buffered,
  // so a returning response always finds a free FIFO slot.
  assign inflight    = {1'b0, outst_q} + {1'b0, count_q};
  assign redir_pc    = i_redirect_pc & 32'hFFFF_FFFC;
  assign o_imem_req  = i_rst_n & ~i_redirect & (inflight < DEPTH_W);
  assign o_imem_addr = fetch_pc_q;

  assign head_vld = i_rst_n & (count_q != '0);
  assign o_valid  = head_vld & ~i_redirect;
  assign o_instr  = head_vld ? instr_mem_q[rd_ptr_q] : NOP;
  assign o_pc     = head_vld ? pc_mem_q[rd_ptr_q] : '0;
  assign o_opcode = o_instr[6:0];

  assign grant = o_imem_req & i_imem_gnt;
  assign pop   = o_valid & i_ready;
  assign push  = ~i_redirect & i_imem_rvalid & (drop_q == '0);

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    outst_d     = outst_q;
    drop_d      = drop_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (i_redirect) begin
      // Every response still owed after this cycle belongs to the old stream.
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      outst_d    = outst_q - CW'(i_imem_rvalid);
      drop_d     = outst_q - CW'(i_imem_rvalid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      outst_d = outst_q + CW'(grant) - CW'(i_imem_rvalid);
      if (i_imem_rvalid && drop_q != '0) drop_d = drop_q - CW'(1);
      if (push) begin
        pc_mem_d[wr_ptr_q]    = resp_pc_q;
        instr_mem_d[wr_ptr_q] = i_imem_rdata;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        resp_pc_d             = resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc_q <= RESET_VEC;
      resp_pc_q  <= RESET_VEC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset; count_q alone decides what is visible.
  always_ff @(posedge i_clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: random imem latency/grant/ready/redirect traffic checked
// every cycle against a queue-based model, plus directed literal scenarios.
module tb_instr_fetch;
  localparam int DEPTH = 4;
  localparam logic [31:0] RVEC = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0, gnt = 1'b0, rvalid = 1'b0, redirect = 1'b0, ready = 1'b0;
  logic [31:0] rdata = '0, redirect_pc = '0;
  logic imem_req, valid;
  logic [31:0] imem_addr, instr, pc;
  logic [6:0] opcode;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_VEC(RVEC), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(gnt),
    .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_valid(valid), .i_ready(ready),
    .o_instr(instr), .o_pc(pc), .o_opcode(opcode));

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] addr; bit stale; } fly_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  mreq_t mem_q[$];
  fly_t  m_if[$];
  ent_t  m_out[$];
  logic [31:0] m_fetch = RVEC;

  int n_vec = 0, n_err = 0, cyc = 0;
  bit rst_drv = 0, gnt_all = 1, rand_redir = 0, redir_once = 0;
  int rdy_mode = 1, lat_min = 1, lat_max = 1;
  logic [31:0] redir_pc_v = '0;
  logic [31:0] pop_log[$], pop_instr[$], gnt_log[$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[26:2], (a[2] ? 7'h03 : 7'h33)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic e_req, e_valid;
    logic [31:0] e_instr, e_pc;
    fly_t it;
    @(posedge clk); #1;
    cyc++;
    rst_n       = rst_drv;
    redirect    = redir_once || (rand_redir && $urandom_range(0, 11) == 0);
    redirect_pc = redir_once ? redir_pc_v : $urandom;
    redir_once  = 0;
    gnt   = gnt_all || ($urandom_range(0, 3) != 0);
    ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    if (rst_drv && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      rvalid = 1'b1; rdata = data_of(mem_q[0].addr);
    end else begin
      rvalid = 1'b0; rdata = $urandom;
    end
    #3;
    e_req   = rst_n && !redirect && (m_if.size() + m_out.size() < DEPTH);
    e_valid = rst_n && !redirect && m_out.size() != 0;
    e_instr = (rst_n && m_out.size() != 0) ? m_out[0].instr : NOP;
    e_pc    = (rst_n && m_out.size() != 0) ? m_out[0].pc : 32'h0;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_addr, m_fetch);
    chk("valid", 32'(valid), 32'(e_valid));
    chk("instr", instr, e_instr);
    chk("pc", pc, e_pc);
    chk("opcode", 32'(opcode), 32'(e_instr[6:0]));
    if (!rst_n) begin
      mem_q.delete(); m_if.delete(); m_out.delete(); m_fetch = RVEC;
    end else begin
      if (rvalid) void'(mem_q.pop_front());
      if (imem_req && gnt) begin
        mem_q.push_back('{imem_addr, cyc + int'($urandom_range(lat_min, lat_max))});
        gnt_log.push_back(imem_addr);
      end
      if (valid && ready) begin pop_log.push_back(pc); pop_instr.push_back(instr); end
      if (redirect) begin
        m_fetch = {redirect_pc[31:2], 2'b00};
        if (rvalid && m_if.size() != 0) void'(m_if.pop_front());
        foreach (m_if[i]) m_if[i].stale = 1'b1;
        m_out.delete();
      end else begin
        if (e_valid && ready) void'(m_out.pop_front());
        if (rvalid && m_if.size() != 0) begin
          it = m_if.pop_front();
          if (!it.stale) m_out.push_back('{it.addr, data_of(it.addr)});
        end
        if (e_req && gnt) begin m_if.push_back('{m_fetch, 1'b0}); m_fetch = m_fetch + 32'd4; end
      end
    end
  endtask

  task automatic do_reset();
    rst_drv = 0; tick(); rst_drv = 1;
  endtask

  initial begin
    int first_valid;
    // Reset held for three cycles
    rst_drv = 0; gnt_all = 1; lat_min = 1; lat_max = 1; rdy_mode = 1;
    repeat (3) tick();
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_opcode", 32'(opcode), 32'h13);

    // Streaming, L=1, always granted and ready
    rst_drv = 1;
    tick();
    chk("first_addr", imem_addr, RVEC);
    chk("first_req", 32'(imem_req), 32'h1);
    pop_log.delete(); pop_instr.delete(); first_valid = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (valid && first_valid < 0) first_valid = k;
    end
    chk("stream_first_valid", 32'(first_valid), 32'd2);
    chk("stream_pops", 32'(pop_log.size()), 32'd9);
    chk("stream_pc0", pop_log[0], 32'h0);
    chk("stream_pc1", pop_log[1], 32'h4);
    chk("stream_pc2", pop_log[2], 32'h8);
    chk("stream_op0", 32'(pop_instr[0][6:0]), 32'h33);
    chk("stream_op1", 32'(pop_instr[1][6:0]), 32'h03);

    // Backpressure: FIFO fills, request stops, nothing lost
    do_reset();
    rdy_mode = 2;
    repeat (10) tick();
    chk("bp_req", 32'(imem_req), 32'h0);
    chk("bp_valid", 32'(valid), 32'h1);
    chk("bp_head", pc, 32'h0);
    pop_log.delete(); rdy_mode = 1;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) chk("bp_order", pop_log[i], 32'(4 * i));

    // Redirect with two responses in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    tick(); tick();
    redir_once = 1; redir_pc_v = 32'h0000_0103;
    tick();
    chk("redir_valid", 32'(valid), 32'h0);
    pop_log.delete();
    tick();
    chk("redir_addr", imem_addr, 32'h0000_0100);
    chk("redir_req", 32'(imem_req), 32'h1);
    repeat (10) tick();
    chk("redir_pop0", pop_log[0], 32'h0000_0100);
    chk("redir_pop1", pop_log[1], 32'h0000_0104);

    // Redirect coinciding with rvalid and a would-be pop
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (3) tick();
    redir_once = 1; redir_pc_v = 32'h0000_0200;
    pop_log.delete();
    tick();
    chk("coinc_valid", 32'(valid), 32'h0);
    repeat (8) tick();
    chk("coinc_pops", 32'(pop_log.size()), 32'd6);
    chk("coinc_pop0", pop_log[0], 32'h0000_0200);

    // Fetch PC wrap at the top of the address space
    gnt_log.delete();
    redir_once = 1; redir_pc_v = 32'hFFFF_FFFB;
    tick();
    repeat (4) tick();
    chk("wrap0", gnt_log[0], 32'hFFFF_FFF8);
    chk("wrap1", gnt_log[1], 32'hFFFF_FFFC);
    chk("wrap2", gnt_log[2], 32'h0000_0000);
    chk("wrap3", gnt_log[3], 32'h0000_0004);

    // Random traffic with occasional redirects and resets
    gnt_all = 0; lat_min = 1; lat_max = 4; rdy_mode = 0; rand_redir = 1;
    for (int k = 0; k < 3000; k++) begin
      rst_drv = ($urandom_range(0, 299) != 0);
      tick();
    end
    rand_redir = 0; rst_drv = 1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
